// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and defaults for uart_rx and uart_tx
//
// Contents:
//   uart_state_e     receiver/transmitter frame state
//   UART_DATA_BITS   default data bits per frame
//   UART_OVERSAMPLE  default oversample ticks per bit period
//   cnt_width()      counter width for a modulus, never below 1 bit
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the asynchronous rx line
//
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset; both flops reset to 1 (line idle)
//   d    asynchronous serial input
//   q    synchronized output
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with overrun and framing error flags
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   rx_en      one-clk oversample tick (OVERSAMPLE x baud)
//   rx         asynchronous serial line, idles high, LSB first
//   rx_data    last correctly framed byte
//   rx_valid   rx_data holds an unread byte
//   rx_ack     consumer read strobe, clears rx_valid
//   overrun    one-clk pulse: byte completed while rx_valid was still high
//   frame_err  one-clk pulse: stop bit sampled low
//   busy       receiver is inside a frame
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 overrun,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = cnt_width(OVERSAMPLE);
    localparam int IDX_W = cnt_width(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_e          state;
    uart_state_e          state_n;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;

    logic cnt_clr;
    logic idx_clr;
    logic sample_bit;
    logic done_ok;
    logic done_err;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (rx_en && !rx_s) begin
                    state_n = ST_START;
                end
            end
            ST_START: begin
                // Mid start bit: a high line here was a glitch, not a frame.
                if (rx_en && cnt == CNT_MID) begin
                    state_n = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_en && cnt == CNT_LAST && idx == IDX_LAST) begin
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (rx_en && cnt == CNT_LAST) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        idx_clr    = rx_en && (state == ST_START) && (cnt == CNT_MID);
        sample_bit = rx_en && (state == ST_DATA) && (cnt == CNT_LAST);
        done_ok    = rx_en && (state == ST_STOP) && (cnt == CNT_LAST) && rx_s;
        done_err   = rx_en && (state == ST_STOP) && (cnt == CNT_LAST) && !rx_s;
        // The tick counter restarts at every bit boundary; after the start-bit
        // midpoint it is aligned so that CNT_LAST lands mid-bit.
        cnt_clr    = rx_en && ((state == ST_IDLE) ||
                               ((state == ST_START) && (cnt == CNT_MID)) ||
                               (((state == ST_DATA) || (state == ST_STOP)) &&
                                (cnt == CNT_LAST)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (rx_en) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (idx_clr) begin
                idx <= '0;
            end else if (sample_bit) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end

            if (sample_bit) begin
                shreg[idx] <= rx_s;
            end

            if (done_ok) begin
                rx_data <= shreg;
            end

            // A completion wins over a same-clk ack: the new byte is unread.
            if (done_ok) begin
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end

            overrun   <= done_ok && rx_valid && !rx_ack;
            frame_err <= done_err;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
`define CHK(tag, obs, exp) \
    begin \
        ncomp++; \
        assert ((obs) === (exp)) else begin \
            nfail++; \
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
        end \
    end

module tb_uart_rx;

    localparam int DB = 8;
    localparam int OS = 16;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          rx_en  = 1'b0;
    logic          rx     = 1'b1;
    logic          rx_ack = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          overrun;
    logic          frame_err;
    logic          busy;

    int   ncomp     = 0;
    int   nfail     = 0;
    int   fe_cnt    = 0;
    int   ov_cnt    = 0;
    int   vrise_cnt = 0;
    int   lat_bad   = 0;
    int   div       = 0;
    logic v_prev    = 1'b0;

    uart_rx #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_en     (rx_en),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .overrun   (overrun),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    // One-clk tick every 27 clks, changed on the falling edge.
    always @(negedge clk) begin
        div   = (div == 26) ? 0 : div + 1;
        rx_en = (div == 26);
    end

    // Pulse and rising-edge tally; rx_valid must rise on the edge of a tick.
    always @(posedge clk) begin
        #1;
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (rx_valid && !v_prev) begin
            vrise_cnt++;
            if (!rx_en) lat_bad++;
        end
        v_prev = rx_valid;
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!rx_en) @(posedge clk);
        end
        #1;
    endtask

    task automatic do_ack();
        @(posedge clk);
        #1 rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
    endtask

    // Start bit begins right after a tick; the mid-stop sample falls on
    // the 153rd tick after that one, which is where ack_on_done strikes.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic ack_on_done);
        wait_ticks(1);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_ticks(16);
        end
        rx = stop_bit;
        wait_ticks(8);
        if (ack_on_done) begin
            repeat (26) @(posedge clk);
            #1;
            `CHK("valid_before_ack", rx_valid, 1'b1)
            rx_ack = 1'b1;
            @(posedge clk);
            #1 rx_ack = 1'b0;
            wait_ticks(7);
        end else begin
            wait_ticks(8);
        end
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0] b55;

        repeat (5) @(posedge clk);
        #1;
        `CHK("reset_valid", rx_valid, 1'b0)
        `CHK("reset_data", rx_data, 8'h00)
        `CHK("reset_busy", busy, 1'b0)
        `CHK("reset_overrun", overrun, 1'b0)
        `CHK("reset_frame_err", frame_err, 1'b0)
        rst = 1'b0;
        wait_ticks(3);

        // Good frame 0xA5
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_ticks(2);
        `CHK("a5_data", rx_data, 8'hA5)
        `CHK("a5_valid", rx_valid, 1'b1)
        `CHK("a5_fe", fe_cnt, 0)
        `CHK("a5_ov", ov_cnt, 0)
        `CHK("a5_rises", vrise_cnt, 1)
        do_ack();
        `CHK("ack_clears_valid", rx_valid, 1'b0)
        do_ack();
        `CHK("ack_idle_ignored", rx_valid, 1'b0)
        `CHK("ack_keeps_data", rx_data, 8'hA5)

        // Framing error on 0x3C
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_ticks(12);
        `CHK("fe_count", fe_cnt, 1)
        `CHK("fe_valid", rx_valid, 1'b0)
        `CHK("fe_data", rx_data, 8'hA5)
        `CHK("fe_busy", busy, 1'b0)

        // False start: 4 ticks low
        wait_ticks(1);
        rx = 1'b0;
        wait_ticks(4);
        `CHK("false_busy_hi", busy, 1'b1)
        rx = 1'b1;
        wait_ticks(8);
        `CHK("false_busy_lo", busy, 1'b0)
        `CHK("false_data", rx_data, 8'hA5)
        `CHK("false_valid", rx_valid, 1'b0)
        `CHK("false_rises", vrise_cnt, 1)
        `CHK("false_fe", fe_cnt, 1)

        // Overrun: 0x00 then 0xFF with no ack
        send_frame(8'h00, 1'b1, 1'b0);
        wait_ticks(2);
        `CHK("b00_data", rx_data, 8'h00)
        `CHK("b00_valid", rx_valid, 1'b1)
        `CHK("b00_ov", ov_cnt, 0)
        send_frame(8'hFF, 1'b1, 1'b0);
        wait_ticks(2);
        `CHK("ovr_count", ov_cnt, 1)
        `CHK("ovr_data", rx_data, 8'hFF)
        `CHK("ovr_valid", rx_valid, 1'b1)

        // Same pair, ack landing on the completion clk of 0xFF
        do_ack();
        `CHK("pre_ack_clear", rx_valid, 1'b0)
        send_frame(8'h00, 1'b1, 1'b0);
        wait_ticks(2);
        `CHK("b00b_data", rx_data, 8'h00)
        send_frame(8'hFF, 1'b1, 1'b1);
        wait_ticks(2);
        `CHK("ackdone_ov", ov_cnt, 1)
        `CHK("ackdone_data", rx_data, 8'hFF)
        `CHK("ackdone_valid", rx_valid, 1'b1)
        `CHK("ackdone_rises", vrise_cnt, 3)

        // Reset in the middle of bit 4 of 0x55, then 0x81
        b55 = 8'h55;
        wait_ticks(1);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx = b55[i];
            wait_ticks(16);
        end
        rx = b55[4];
        wait_ticks(8);
        `CHK("mid_busy", busy, 1'b1)
        rst = 1'b1;
        #1;
        `CHK("async_busy", busy, 1'b0)
        `CHK("async_valid", rx_valid, 1'b0)
        `CHK("async_data", rx_data, 8'h00)
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rx = 1'b1;
        wait_ticks(20);
        `CHK("post_rst_valid", rx_valid, 1'b0)
        send_frame(8'h81, 1'b1, 1'b0);
        wait_ticks(2);
        `CHK("b81_data", rx_data, 8'h81)
        `CHK("b81_valid", rx_valid, 1'b1)
        `CHK("b81_rises", vrise_cnt, 4)
        `CHK("b81_ov", ov_cnt, 1)
        `CHK("b81_fe", fe_cnt, 1)
        `CHK("valid_latency", lat_bad, 0)

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8: number of data bits per frame.
REQ-002 Parameter OVERSAMPLE, default 16: rx_en ticks per bit period.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 rx_en  input  1  one-clk oversample tick at OVERSAMPLE x baud rate from the baud generator.
REQ-006 rx  input  1  asynchronous serial line; idles high.
REQ-007 rx_data  output  DATA_BITS  last correctly framed byte, LSB first on the line.
REQ-008 rx_valid  output  1  level; rx_data holds an unread byte.
REQ-009 rx_ack  input  1  consumer read strobe; clears rx_valid.
REQ-010 overrun  output  1  one-clk pulse; a byte completed while rx_valid was still high.
REQ-011 frame_err  output  1  one-clk pulse; stop bit sampled low.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer before any use; the synchronizer resets to 1.
REQ-014 The FSM SHALL have states IDLE, START, DATA and STOP, and SHALL advance only on clocks where rx_en=1.
REQ-015 In IDLE, synced rx=0 on a tick SHALL move the FSM to START and clear the tick counter.
REQ-016 In START, at the tick where the counter reaches OVERSAMPLE/2-1 (7), synced rx=0 SHALL move the FSM to DATA with counter and bit index cleared; synced rx=1 SHALL return the FSM to IDLE (false start, no outputs).
REQ-017 In DATA, every OVERSAMPLE ticks (counter = 15) SHALL sample synced rx into bit[index], LSB first; after bit DATA_BITS-1 the FSM SHALL move to STOP.
REQ-018 In STOP, at counter = 15 (mid stop bit), synced rx=1 SHALL load rx_data, set rx_valid, and return to IDLE on the same tick.
REQ-019 In STOP, synced rx=0 SHALL pulse frame_err for one clk, leave rx_data and rx_valid unchanged, and return to IDLE.
REQ-020 Completion while rx_valid=1 with rx_ack=0 SHALL overwrite rx_data, keep rx_valid=1, and pulse overrun.
REQ-021 Completion with rx_ack=1 on the same clk SHALL load the new byte, keep rx_valid=1, and produce no overrun.
REQ-022 rx_ack with no completion on that clk SHALL clear rx_valid on the next edge; rx_ack while rx_valid=0 SHALL be ignored.
REQ-023 Latency: rx_valid SHALL rise 1 clk after the rx_en tick at mid stop bit.
REQ-024 Tick and bit counters SHALL be sized exactly for OVERSAMPLE and DATA_BITS and SHALL wrap to 0 on each bit boundary.

Reset
REQ-025 Asserting rst SHALL force IDLE, rx_data=0, rx_valid=0, overrun=0, frame_err=0, busy=0, counters=0 and synchronizer=1, asynchronously.
REQ-026 rst mid-frame SHALL discard the partial byte; the receiver SHALL resynchronize on the next falling edge after release.

Structure
REQ-027 Package uart_pkg SHALL hold the FSM state type and the DATA_BITS and OVERSAMPLE defaults; uart_tx shall use the same package.
REQ-028 The synchronizer SHALL be a separate sub-module, uart_rx_sync; all other logic SHALL stay in uart_rx.

Verification (clk 50 MHz, rx_en every 27 clks, bit period 432 clks)
REQ-029 Frame 0xA5 with a valid stop bit -> rx_data=0xA5, rx_valid=1 with no error pulses; rx_ack -> rx_valid=0 next clk.
REQ-030 Frame 0x3C with stop bit low -> frame_err pulses once, rx_valid stays 0, rx_data unchanged.
REQ-031 rx low for 4 ticks, then high -> FSM returns to IDLE, busy falls, no outputs change.
REQ-032 Bytes 0x00 then 0xFF back-to-back with no ack -> overrun pulses once, rx_data=0xFF; repeat with rx_ack on the completion clk -> no overrun.
REQ-033 rst asserted in the middle of bit 4 of frame 0x55, then frame 0x81 -> no byte for 0x55, rx_data=0x81.
